// File: rtl/uart_rx_os_if.sv
// Bus-side view of the oversampling UART receiver: FIFO read port,
// occupancy/status flags and the sticky overrun control.
interface uart_rx_os_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic          clr_overrun;
    logic [7:0]    rd_data;
    logic [2:0]    rd_err;
    logic          rx_empty;
    logic          rx_full;
    logic [CW-1:0] rx_count;
    logic          overrun;

    // Bus host: pops characters and clears the overrun flag
    modport master (
        output rd_en,
        output clr_overrun,
        input  rd_data,
        input  rd_err,
        input  rx_empty,
        input  rx_full,
        input  rx_count,
        input  overrun
    );

    // Receiver: owns the FIFO and reports its state
    modport slave (
        input  rd_en,
        input  clr_overrun,
        output rd_data,
        output rd_err,
        output rx_empty,
        output rx_full,
        output rx_count,
        output overrun
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with runtime-programmable baud tick,
// 5-8 data bits, optional odd/even parity, 1 or 2 stop bits, 3-sample
// majority voting and a first-word-fall-through receive FIFO that
// stores each character together with its {break, parity, frame} status.
module uart_rx_os #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             data_tx,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_len,
    input  logic [1:0]       parity_type,
    input  logic             stop2,
    output logic             active_flag,
    uart_rx_os_if.slave      bus
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_DEC = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t state;
    state_t state_next;

    logic             sync1;
    logic             rx_s;
    logic             rx_q;
    logic             start_det;

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;

    logic [SW-1:0]    sample_cnt;
    logic             dec;
    logic             bit_end;
    logic             vote0;
    logic             vote1;
    logic             bit_val;
    logic             bit_reg;

    logic [1:0]       len_l;
    logic [1:0]       par_l;
    logic             stop2_l;
    logic             par_en;
    logic [2:0]       last_idx;

    logic [7:0]       data_reg;
    logic [2:0]       bit_idx;
    logic             par_bit;
    logic             stop1_bad;

    logic             fifo_wr;
    logic [2:0]       wr_err;
    logic             exp_par;
    logic             frm;
    logic             brk;

    logic [7:0]       mem_data [FIFO_DEPTH];
    logic [2:0]       mem_err  [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             do_wr;
    logic             do_rd;
    logic             ovr_set;
    logic             overrun_q;

    // Two-flop synchroniser plus edge register; idle-high so reset never fakes an edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            sync1 <= data_tx;
            rx_s  <= sync1;
            rx_q  <= rx_s;
        end
    end

    assign start_det = (state == IDLE) && rx_q && !rx_s;

    assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
    assign tick    = (tick_cnt >= div_eff - DIV_W'(1));

    // Baud tick divider, re-phased to the start edge of every frame
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (start_det || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    assign dec     = tick && (sample_cnt == S_DEC);
    assign bit_end = tick && (sample_cnt == S_END);

    // Position within the current bit, counted in sample ticks
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample_cnt <= '0;
        end else if (start_det) begin
            sample_cnt <= '0;
        end else if (tick && (state != IDLE)) begin
            sample_cnt <= (sample_cnt == S_END) ? '0 : sample_cnt + SW'(1);
        end
    end

    // Capture the two early votes; the third is the live sample at the decision tick
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vote0 <= 1'b1;
            vote1 <= 1'b1;
        end else if (tick) begin
            if (sample_cnt == S_V0) vote0 <= rx_s;
            if (sample_cnt == S_V1) vote1 <= rx_s;
        end
    end

    assign bit_val = (vote0 & vote1) | (vote0 & rx_s) | (vote1 & rx_s);

    // Frame format is frozen at the start edge so mid-frame changes wait for the next frame
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_l   <= 2'b11;
            par_l   <= 2'b00;
            stop2_l <= 1'b0;
        end else if (start_det) begin
            len_l   <= data_len;
            par_l   <= parity_type;
            stop2_l <= stop2;
        end
    end

    assign par_en   = (par_l == 2'b01) || (par_l == 2'b10);
    assign last_idx = {1'b1, len_l};

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: bits advance at the end of their period, the last stop bit at its decision
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_det) state_next = START;
            end
            START: begin
                if (bit_end) state_next = bit_reg ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end && (bit_idx == last_idx)) state_next = par_en ? PARITY : STOP1;
            end
            PARITY: begin
                if (bit_end) state_next = STOP1;
            end
            STOP1: begin
                if (dec && !stop2_l)         state_next = IDLE;
                else if (bit_end && stop2_l) state_next = STOP2;
            end
            STOP2: begin
                if (dec) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Receive datapath: decided bit, data bits placed by index, parity and first stop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_reg   <= 1'b1;
            data_reg  <= '0;
            bit_idx   <= '0;
            par_bit   <= 1'b0;
            stop1_bad <= 1'b0;
        end else if (start_det) begin
            data_reg  <= '0;
            bit_idx   <= '0;
            par_bit   <= 1'b0;
            stop1_bad <= 1'b0;
        end else begin
            if (dec) begin
                bit_reg <= bit_val;
                case (state)
                    DATA:    data_reg[bit_idx] <= bit_val;
                    PARITY:  par_bit           <= bit_val;
                    STOP1:   stop1_bad         <= !bit_val;
                    default: ;
                endcase
            end
            if (bit_end && (state == DATA)) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // FSM outputs: FIFO write strobe and the status word of the completed character
    always_comb begin
        fifo_wr = 1'b0;
        exp_par = (par_l == 2'b01) ? ~^data_reg : ^data_reg;
        frm     = 1'b0;
        brk     = 1'b0;
        wr_err  = 3'b000;
        case (state)
            STOP1: begin
                fifo_wr = dec && !stop2_l;
                frm     = !bit_val;
                brk     = (data_reg == 8'h00) && (!par_en || !par_bit) && !bit_val;
            end
            STOP2: begin
                fifo_wr = dec;
                frm     = stop1_bad || !bit_val;
                brk     = (data_reg == 8'h00) && (!par_en || !par_bit) && stop1_bad;
            end
            default: ;
        endcase
        // A break is a line condition rather than a character, so its parity is not reported
        wr_err = {brk, par_en && (par_bit != exp_par) && !brk, frm};
    end

    assign active_flag = (state != IDLE);

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = bus.rd_en && !empty;
    assign do_wr   = fifo_wr && (!full || bus.rd_en);
    assign ovr_set = fifo_wr && full && !bus.rd_en;

    // FIFO storage; a write while full is only accepted when the head is popped at the same edge
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_data[wr_ptr] <= data_reg;
            mem_err[wr_ptr]  <= wr_err;
        end
    end

    // FIFO pointers and occupancy, wrapping naturally at the power-of-two depth
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overrun; a new drop in the same cycle as a clear keeps it set
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (ovr_set) begin
            overrun_q <= 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.rd_data  = empty ? 8'h00 : mem_data[rd_ptr];
    assign bus.rd_err   = empty ? 3'b000 : mem_err[rd_ptr];
    assign bus.rx_empty = empty;
    assign bus.rx_full  = full;
    assign bus.rx_count = count;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 16x oversampling, baud_div=4, 4-entry FIFO.
module tb_uart_rx_os;

    localparam int OS       = 16;
    localparam int DEPTH    = 4;
    localparam int DIVV     = 4;
    localparam int BIT_CLKS = OS * DIVV;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_tx = 1'b1;
    logic [15:0] baud_div = 16'(DIVV);
    logic [1:0]  data_len = 2'b11;
    logic [1:0]  parity_type = 2'b00;
    logic        stop2 = 1'b0;
    logic        active_flag;

    int compared = 0;
    int mismatched = 0;
    int act_cycles = 0;

    uart_rx_os_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_os #(
        .OVERSAMPLE (OS),
        .DIV_W      (16),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data_tx     (data_tx),
        .baud_div    (baud_div),
        .data_len    (data_len),
        .parity_type (parity_type),
        .stop2       (stop2),
        .active_flag (active_flag),
        .bus         (bus)
    );

    // Free-running system clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drive_bit(input logic b);
        data_tx = b;
        repeat (BIT_CLKS) begin
            @(negedge clock);
            act_cycles += int'(active_flag);
        end
    endtask

    // Send one frame followed by one idle bit time
    task automatic applyStimulus(input logic [7:0] data, input int nbits, input logic [1:0] ptype,
                                 input logic two_stop, input logic par_flip, input logic stop2_val);
        logic [7:0] d;
        logic       p;
        data_len    = 2'(nbits - 5);
        parity_type = ptype;
        stop2       = two_stop;
        d = data & ((8'h01 << nbits) - 8'h01);
        p = (ptype == 2'b01) ? ~^d : ^d;
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (ptype == 2'b01 || ptype == 2'b10) drive_bit(p ^ par_flip);
        drive_bit(1'b1);
        if (two_stop) drive_bit(stop2_val);
        drive_bit(1'b1);
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        @(negedge clock);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        bus.rd_en       = 1'b0;
        bus.clr_overrun = 1'b0;

        // Reset values
        repeat (3) @(negedge clock);
        checkOutput("rst_empty",   32'(bus.rx_empty), 32'd1);
        checkOutput("rst_full",    32'(bus.rx_full),  32'd0);
        checkOutput("rst_count",   32'(bus.rx_count), 32'd0);
        checkOutput("rst_overrun", 32'(bus.overrun),  32'd0);
        checkOutput("rst_active",  32'(active_flag),  32'd0);
        checkOutput("rst_rd_data", 32'(bus.rd_data),  32'h00);
        checkOutput("rst_rd_err",  32'(bus.rd_err),   32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // 8N1 0xA5
        $display("[TB] 8N1 0xA5");
        act_cycles = 0;
        applyStimulus(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("a5_count",  32'(bus.rx_count), 32'd1);
        checkOutput("a5_data",   32'(bus.rd_data),  32'hA5);
        checkOutput("a5_err",    32'(bus.rd_err),   32'b000);
        checkOutput("a5_active_len", 32'(act_cycles >= 600 && act_cycles <= 630), 32'd1);
        checkOutput("a5_active_end", 32'(active_flag), 32'd0);
        pop_one();
        checkOutput("a5_popped", 32'(bus.rx_empty), 32'd1);

        // 7E2 with a wrong parity bit, then with a bad second stop bit
        $display("[TB] 7E2 0x35");
        applyStimulus(8'h35, 7, 2'b10, 1'b1, 1'b1, 1'b1);
        checkOutput("par_data", 32'(bus.rd_data), 32'h35);
        checkOutput("par_err",  32'(bus.rd_err),  32'b010);
        pop_one();
        applyStimulus(8'h35, 7, 2'b10, 1'b1, 1'b0, 1'b0);
        checkOutput("stop2_data", 32'(bus.rd_data), 32'h35);
        checkOutput("stop2_err",  32'(bus.rd_err),  32'b001);
        pop_one();

        // Glitch shorter than half a bit is a false start
        $display("[TB] glitch");
        data_len = 2'b11; parity_type = 2'b00; stop2 = 1'b0;
        data_tx = 1'b0;
        repeat (3 * DIVV) @(negedge clock);
        data_tx = 1'b1;
        checkOutput("glitch_active", 32'(active_flag), 32'd1);
        repeat (2 * BIT_CLKS) @(negedge clock);
        checkOutput("glitch_idle",  32'(active_flag),  32'd0);
        checkOutput("glitch_empty", 32'(bus.rx_empty), 32'd1);

        // Break with 8O1: line low for 12 bit times
        $display("[TB] break 8O1");
        data_len = 2'b11; parity_type = 2'b01; stop2 = 1'b0;
        data_tx = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clock);
        data_tx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clock);
        checkOutput("brk_count", 32'(bus.rx_count), 32'd1);
        checkOutput("brk_data",  32'(bus.rd_data),  32'h00);
        checkOutput("brk_err",   32'(bus.rd_err),   32'b101);
        repeat (2 * BIT_CLKS) @(negedge clock);
        checkOutput("brk_single", 32'(bus.rx_count), 32'd1);
        pop_one();

        // Fill the FIFO and overflow it
        $display("[TB] overrun");
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h11 + i), 8, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("ovr_count", 32'(bus.rx_count), 32'd4);
        checkOutput("ovr_full",  32'(bus.rx_full),  32'd1);
        checkOutput("ovr_flag",  32'(bus.overrun),  32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ovr_read", 32'(bus.rd_data), 32'(8'h11 + i));
            pop_one();
        end
        checkOutput("ovr_drained", 32'(bus.rx_empty), 32'd1);
        pop_one();
        checkOutput("empty_read_count", 32'(bus.rx_count), 32'd0);
        checkOutput("ovr_sticky", 32'(bus.overrun), 32'd1);
        bus.clr_overrun = 1'b1;
        @(negedge clock);
        bus.clr_overrun = 1'b0;
        checkOutput("ovr_cleared", 32'(bus.overrun), 32'd0);

        // Reset in the middle of the data bits of 0x5A
        $display("[TB] reset mid-frame");
        applyStimulus(8'h77, 8, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("pre_rst_count", 32'(bus.rx_count), 32'd1);
        data_len = 2'b11; parity_type = 2'b00; stop2 = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset_n = 1'b0;
        data_tx = 1'b1;
        @(negedge clock);
        checkOutput("mid_rst_active",  32'(active_flag),  32'd0);
        checkOutput("mid_rst_count",   32'(bus.rx_count), 32'd0);
        checkOutput("mid_rst_empty",   32'(bus.rx_empty), 32'd1);
        checkOutput("mid_rst_rd_data", 32'(bus.rd_data),  32'h00);
        checkOutput("mid_rst_rd_err",  32'(bus.rd_err),   32'd0);
        reset_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clock);
        applyStimulus(8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("post_rst_count", 32'(bus.rx_count), 32'd1);
        checkOutput("post_rst_data",  32'(bus.rd_data),  32'h3C);
        checkOutput("post_rst_err",   32'(bus.rd_err),   32'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
